// File: rtl/vic_raster_gen.sv
// VIC-II style raster timing generator: dot/cycle/line counters, phase clock,
// sync and display-window decodes, and a line-compare raster interrupt.
module vic_raster_gen #(
  parameter int DOTS_PER_CYCLE  = 8,
  parameter int CYCLES_PER_LINE = 63,
  parameter int LINES_PER_FRAME = 312,
  parameter int RASTER_W        = 9,
  parameter int HSYNC_START     = 58,
  parameter int HSYNC_LEN       = 4,
  parameter int VSYNC_START     = 300,
  parameter int VSYNC_LEN       = 3,
  parameter int DISP_X0         = 16,
  parameter int DISP_X1         = 55,
  parameter int DISP_Y0         = 51,
  parameter int DISP_Y1         = 250,
  localparam int CW             = $clog2(CYCLES_PER_LINE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_dot_en,
  input  logic [RASTER_W-1:0] i_raster_cmp,
  input  logic                i_irq_en,
  input  logic                i_irq_ack,
  output logic                o_clkPhi0,
  output logic                o_phi0_rise,
  output logic [CW-1:0]       o_cycle,
  output logic [RASTER_W-1:0] o_raster,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_display_on,
  output logic                o_frame_start,
  output logic                o_irq
);

  localparam int DW = $clog2(DOTS_PER_CYCLE);

  localparam logic [DW-1:0]       DOT_LAST  = DW'(DOTS_PER_CYCLE - 1);
  localparam logic [DW-1:0]       DOT_HALF  = DW'(DOTS_PER_CYCLE / 2);
  localparam logic [CW-1:0]       CYC_LAST  = CW'(CYCLES_PER_LINE - 1);
  localparam logic [RASTER_W-1:0] LINE_LAST = RASTER_W'(LINES_PER_FRAME - 1);

  // Decode bounds carry one extra bit so START+LEN may reach 2**width.
  localparam logic [CW:0]       HS_LO = (CW+1)'(HSYNC_START);
  localparam logic [CW:0]       HS_HI = (CW+1)'(HSYNC_START + HSYNC_LEN);
  localparam logic [RASTER_W:0] VS_LO = (RASTER_W+1)'(VSYNC_START);
  localparam logic [RASTER_W:0] VS_HI = (RASTER_W+1)'(VSYNC_START + VSYNC_LEN);
  localparam logic [CW:0]       DX0   = (CW+1)'(DISP_X0);
  localparam logic [CW:0]       DX1   = (CW+1)'(DISP_X1);
  localparam logic [RASTER_W:0] DY0   = (RASTER_W+1)'(DISP_Y0);
  localparam logic [RASTER_W:0] DY1   = (RASTER_W+1)'(DISP_Y1);

  logic [DW-1:0]       dot_cnt, dot_nxt;
  logic [CW-1:0]       cycle;
  logic [RASTER_W-1:0] raster, raster_nxt;
  logic                clk_phi0, phi0_rise, frame_start, irq_flag;
  logic                dot_wrap, line_wrap, irq_set;
  logic [CW:0]         cyc_x;
  logic [RASTER_W:0]   ras_x;

  always_comb begin
    dot_wrap   = i_dot_en && (dot_cnt == DOT_LAST);
    line_wrap  = dot_wrap && (cycle == CYC_LAST);
    dot_nxt    = (dot_cnt == DOT_LAST) ? '0 : dot_cnt + 1'b1;
    raster_nxt = (raster == LINE_LAST) ? '0 : raster + 1'b1;
    // Only the line transition is compared; raster_nxt never reaches LINES_PER_FRAME.
    irq_set    = line_wrap && (raster_nxt == i_raster_cmp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dot_cnt     <= '0;
      cycle       <= '0;
      raster      <= '0;
      clk_phi0    <= 1'b0;
      phi0_rise   <= 1'b0;
      frame_start <= 1'b0;
      irq_flag    <= 1'b0;
    end else begin
      phi0_rise   <= 1'b0;
      frame_start <= 1'b0;
      if (i_dot_en) begin
        dot_cnt   <= dot_nxt;
        clk_phi0  <= (dot_nxt >= DOT_HALF);
        phi0_rise <= (dot_nxt == DOT_HALF);
        if (dot_wrap)
          cycle <= (cycle == CYC_LAST) ? '0 : cycle + 1'b1;
        if (line_wrap) begin
          raster      <= raster_nxt;
          frame_start <= (raster == LINE_LAST);
        end
      end
      // A coincident set beats the acknowledge.
      if (irq_set)
        irq_flag <= 1'b1;
      else if (i_irq_ack)
        irq_flag <= 1'b0;
    end
  end

  always_comb begin
    cyc_x        = {1'b0, cycle};
    ras_x        = {1'b0, raster};
    o_hsync      = (cyc_x >= HS_LO) && (cyc_x < HS_HI);
    o_vsync      = (ras_x >= VS_LO) && (ras_x < VS_HI);
    o_display_on = (cyc_x >= DX0) && (cyc_x <= DX1) && (ras_x >= DY0) && (ras_x <= DY1);
  end

  assign o_clkPhi0     = clk_phi0;
  assign o_phi0_rise   = phi0_rise;
  assign o_cycle       = cycle;
  assign o_raster      = raster;
  assign o_frame_start = frame_start;
  assign o_irq         = irq_flag & i_irq_en;

endmodule

// File: tb/tb_vic_raster_gen.sv
// Bench for vic_raster_gen: a 2-dot instance tracked step by step against a
// queued reference model, plus a default 8-dot instance for phase/line timing.
module tb_vic_raster_gen;
  localparam int DPC = 2;
  localparam int CPL = 63;
  localparam int LPF = 312;

  logic       clk = 1'b0;
  logic       reset, dot_en, irq_en, irq_ack;
  logic [8:0] raster_cmp;

  logic       phi0, rise, hs, vs, de, fs, irq;
  logic [5:0] cyc;
  logic [8:0] ras;
  logic       p8_phi0, p8_rise, p8_hs, p8_vs, p8_de, p8_fs, p8_irq;
  logic [5:0] p8_cyc;
  logic [8:0] p8_ras;

  always #5 clk = ~clk;

  vic_raster_gen #(.DOTS_PER_CYCLE(DPC)) dut (
    .clk(clk), .reset(reset), .i_dot_en(dot_en), .i_raster_cmp(raster_cmp),
    .i_irq_en(irq_en), .i_irq_ack(irq_ack), .o_clkPhi0(phi0), .o_phi0_rise(rise),
    .o_cycle(cyc), .o_raster(ras), .o_hsync(hs), .o_vsync(vs), .o_display_on(de),
    .o_frame_start(fs), .o_irq(irq)
  );

  vic_raster_gen dut8 (
    .clk(clk), .reset(reset), .i_dot_en(dot_en), .i_raster_cmp(raster_cmp),
    .i_irq_en(irq_en), .i_irq_ack(irq_ack), .o_clkPhi0(p8_phi0), .o_phi0_rise(p8_rise),
    .o_cycle(p8_cyc), .o_raster(p8_ras), .o_hsync(p8_hs), .o_vsync(p8_vs),
    .o_display_on(p8_de), .o_frame_start(p8_fs), .o_irq(p8_irq)
  );

  typedef struct packed {
    logic       phi0, rise;
    logic [5:0] cyc;
    logic [8:0] ras;
    logic       hs, vs, de, fs, irq;
  } obs_t;

  typedef struct packed {
    logic       phi0, rise;
    logic [5:0] cyc;
    logic [8:0] ras;
  } ph_t;

  obs_t q[$];
  ph_t  q8[$];
  int   n_chk = 0;
  int   n_fail = 0;

  int m_dot, m_cyc, m_ras;
  bit m_phi0, m_rise, m_fs, m_flag;

  function automatic obs_t actual();
    return {phi0, rise, cyc, ras, hs, vs, de, fs, irq};
  endfunction

  // Drive one clk of stimulus, advance the reference model, queue its expectation.
  task automatic step(input logic rst, input logic den, input logic ack);
    obs_t e;
    bit   set;
    reset = rst; dot_en = den; irq_ack = ack;
    set = 0;
    if (rst) begin
      m_dot = 0; m_cyc = 0; m_ras = 0;
      m_phi0 = 0; m_rise = 0; m_fs = 0; m_flag = 0;
    end else begin
      m_rise = 0; m_fs = 0;
      if (den) begin
        if (m_dot == DPC - 1) begin
          m_dot = 0;
          if (m_cyc == CPL - 1) begin
            m_cyc = 0;
            m_ras = (m_ras == LPF - 1) ? 0 : m_ras + 1;
            m_fs  = (m_ras == 0);
            set   = (m_ras == int'(raster_cmp));
          end else m_cyc++;
        end else begin
          m_dot++;
          m_rise = (m_dot == DPC / 2);
        end
        m_phi0 = (m_dot >= DPC / 2);
      end
      if (set) m_flag = 1;
      else if (ack) m_flag = 0;
    end
    e.phi0 = m_phi0;
    e.rise = m_rise;
    e.cyc  = 6'(m_cyc);
    e.ras  = 9'(m_ras);
    e.hs   = (m_cyc >= 58) && (m_cyc < 62);
    e.vs   = (m_ras >= 300) && (m_ras < 303);
    e.de   = (m_cyc >= 16) && (m_cyc <= 55) && (m_ras >= 51) && (m_ras <= 250);
    e.fs   = m_fs;
    e.irq  = m_flag & irq_en;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    obs_t e, a;
    irq_en = 1'b0; raster_cmp = '0;
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0);
      e = q.pop_front(); a = actual(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL reset: got %h want %h", a, e); end
    end
    n_chk++;
    if ({phi0, rise, cyc, ras, fs, irq, hs, vs, de, p8_phi0, p8_cyc, p8_ras} !== '0) begin
      n_fail++;
      $display("FAIL reset_zero: got %b %b %0d %0d %b %b %b%b%b / dut8 %b %0d %0d want all 0",
               phi0, rise, cyc, ras, fs, irq, hs, vs, de, p8_phi0, p8_cyc, p8_ras);
    end
  endtask

  task automatic test_phase_clock();
    obs_t e, a;
    ph_t  e8, a8;
    step(1, 0, 0);
    e = q.pop_front(); a = actual(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL phase_reset: got %h want %h", a, e); end
    for (int p = 1; p <= 8; p++) begin
      q8.push_back({(p >= 4 && p < 8) ? 1'b1 : 1'b0, (p == 4) ? 1'b1 : 1'b0,
                    (p == 8) ? 6'd1 : 6'd0, 9'd0});
      step(0, 1, 0);
      e = q.pop_front(); a = actual(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL phase2 p%0d: got %h want %h", p, a, e); end
      e8 = q8.pop_front(); a8 = {p8_phi0, p8_rise, p8_cyc, p8_ras}; n_chk++;
      if (a8 !== e8) begin n_fail++; $display("FAIL phase8 p%0d: got %h want %h", p, a8, e8); end
    end
  endtask

  task automatic test_line();
    obs_t e, a;
    ph_t  e8, a8;
    for (int p = 9; p <= 504; p++) begin
      if (p == 504) q8.push_back({1'b0, 1'b0, 6'd0, 9'd1});
      step(0, 1, 0);
      e = q.pop_front(); a = actual(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL line p%0d: got %h want %h", p, a, e); end
    end
    e8 = q8.pop_front(); a8 = {p8_phi0, p8_rise, p8_cyc, p8_ras}; n_chk++;
    if (a8 !== e8) begin n_fail++; $display("FAIL line8_504: got %h want %h", a8, e8); end
  endtask

  task automatic test_gating();
    obs_t e, a;
    int   strobes = 0;
    for (int i = 0; i < 200 && m_cyc != 20; i++) begin
      step(0, 1, 0);
      e = q.pop_front(); a = actual(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL gate_pre: got %h want %h", a, e); end
    end
    step(0, 1, 0);
    e = q.pop_front(); a = actual(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL gate_phi: got %h want %h", a, e); end
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0);
      e = q.pop_front(); a = actual(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL gate_hold %0d: got %h want %h", i, a, e); end
      if (rise || fs || p8_rise || p8_fs) strobes++;
    end
    n_chk++;
    if ({ras, cyc, phi0} !== {9'd4, 6'd20, 1'b1} || strobes != 0) begin
      n_fail++;
      $display("FAIL gate_state: got ras %0d cyc %0d phi0 %b strobes %0d want 4 20 1 0",
               ras, cyc, phi0, strobes);
    end
  endtask

  task automatic test_irq();
    obs_t e, a;
    int   first = -1;
    step(1, 0, 0);
    e = q.pop_front(); a = actual(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL irq_reset: got %h want %h", a, e); end
    raster_cmp = 9'd5; irq_en = 1'b1;
    for (int i = 0; i < 2000 && first < 0; i++) begin
      step(0, 1, 0);
      e = q.pop_front(); a = actual(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL irq_run: got %h want %h", a, e); end
      if (irq === 1'b1) first = int'(ras) * 64 + int'(cyc);
    end
    n_chk++;
    if (first != 5 * 64) begin
      n_fail++; $display("FAIL irq_line: got ras*64+cyc %0d want %0d", first, 5 * 64);
    end
    step(0, 0, 1);
    e = q.pop_front(); a = actual(); n_chk++;
    if (a !== e || irq !== 1'b0) begin n_fail++; $display("FAIL irq_ack: got %h want %h", a, e); end
    for (int i = 0; i < 500 && !(m_ras == 6 && m_cyc == 20); i++) begin
      step(0, 1, 0);
      e = q.pop_front(); a = actual(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL irq_to6: got %h want %h", a, e); end
    end
    raster_cmp = 9'd6;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0);
      e = q.pop_front(); a = actual(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL irq_mid: got %h want %h", a, e); end
    end
    n_chk++;
    if (irq !== 1'b0 || ras !== 9'd6) begin
      n_fail++; $display("FAIL irq_midline: got irq %b ras %0d want 0 6", irq, ras);
    end
    raster_cmp = 9'd8;
    for (int i = 0; i < 500 && !(m_ras == 7 && m_cyc == CPL - 1 && m_dot == DPC - 1); i++) begin
      step(0, 1, 0);
      e = q.pop_front(); a = actual(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL irq_to8: got %h want %h", a, e); end
    end
    step(0, 1, 1);
    e = q.pop_front(); a = actual(); n_chk++;
    if (a !== e || irq !== 1'b1 || ras !== 9'd8) begin
      n_fail++; $display("FAIL irq_ack_vs_set: got %h want %h", a, e);
    end
    irq_en = 1'b0;
    step(0, 0, 0);
    e = q.pop_front(); a = actual(); n_chk++;
    if (a !== e || irq !== 1'b0) begin n_fail++; $display("FAIL irq_mask: got %h want %h", a, e); end
    irq_en = 1'b1;
    step(0, 0, 0);
    e = q.pop_front(); a = actual(); n_chk++;
    if (a !== e || irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmask: got %h want %h", a, e); end
    step(0, 0, 1);
    e = q.pop_front(); a = actual(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL irq_clear: got %h want %h", a, e); end
  endtask

  task automatic test_frame();
    obs_t e, a;
    int fs_cnt = 0, fs_ras = -1, irq_early = 0, de_first = -1;
    int hs_min = 999, hs_max = -1, vs_min = 999, vs_max = -1;
    step(1, 0, 0);
    e = q.pop_front(); a = actual(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL frame_reset: got %h want %h", a, e); end
    raster_cmp = 9'd400; irq_en = 1'b1;
    for (int i = 0; i < LPF * CPL * DPC + 4; i++) begin
      if (m_ras == LPF - 1 && m_cyc == 40) raster_cmp = 9'd0;
      step(0, 1, 0);
      e = q.pop_front(); a = actual(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL frame step %0d: got %h want %h", i, a, e); end
      if (fs === 1'b1) begin fs_cnt++; fs_ras = int'(ras); end
      if (irq === 1'b1 && fs_cnt == 0) irq_early++;
      if (de === 1'b1 && de_first < 0) de_first = int'(ras) * 64 + int'(cyc);
      if (hs === 1'b1) begin
        if (int'(cyc) < hs_min) hs_min = int'(cyc);
        if (int'(cyc) > hs_max) hs_max = int'(cyc);
      end
      if (vs === 1'b1) begin
        if (int'(ras) < vs_min) vs_min = int'(ras);
        if (int'(ras) > vs_max) vs_max = int'(ras);
      end
    end
    n_chk++;
    if (fs_cnt != 1 || fs_ras != 0) begin
      n_fail++; $display("FAIL frame_start: got count %0d ras %0d want 1 0", fs_cnt, fs_ras);
    end
    n_chk++;
    if (irq_early != 0) begin n_fail++; $display("FAIL irq_cmp400: got %0d irq clks want 0", irq_early); end
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_wrap0: got %b want 1", irq); end
    n_chk++;
    if (de_first != 51 * 64 + 16) begin
      n_fail++; $display("FAIL display_first: got %0d want %0d", de_first, 51 * 64 + 16);
    end
    n_chk++;
    if (hs_min != 58 || hs_max != 61) begin
      n_fail++; $display("FAIL hsync_range: got %0d..%0d want 58..61", hs_min, hs_max);
    end
    n_chk++;
    if (vs_min != 300 || vs_max != 302) begin
      n_fail++; $display("FAIL vsync_range: got %0d..%0d want 300..302", vs_min, vs_max);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, a;
    step(1, 0, 0);
    e = q.pop_front(); a = actual(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL mid_reset0: got %h want %h", a, e); end
    raster_cmp = 9'd50; irq_en = 1'b1;
    for (int i = 0; i < 20000 && !(m_ras == 100 && m_cyc == 30); i++) begin
      step(0, 1, 0);
      e = q.pop_front(); a = actual(); n_chk++;
      if (a !== e) begin n_fail++; $display("FAIL mid_run: got %h want %h", a, e); end
    end
    n_chk++;
    if (irq !== 1'b1 || ras !== 9'd100 || cyc !== 6'd30) begin
      n_fail++; $display("FAIL pre_reset: got irq %b ras %0d cyc %0d want 1 100 30", irq, ras, cyc);
    end
    step(1, 1, 0);
    e = q.pop_front(); a = actual(); n_chk++;
    if (a !== e) begin n_fail++; $display("FAIL mid_reset: got %h want %h", a, e); end
    n_chk++;
    if ({ras, cyc, phi0, irq, p8_ras, p8_cyc, p8_phi0, p8_irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_zero: got %0d %0d %b %b / %0d %0d %b %b want all 0",
               ras, cyc, phi0, irq, p8_ras, p8_cyc, p8_phi0, p8_irq);
    end
  endtask

  initial begin
    reset = 1'b1; dot_en = 1'b0; irq_en = 1'b0; irq_ack = 1'b0; raster_cmp = '0;
    m_dot = 0; m_cyc = 0; m_ras = 0;
    m_phi0 = 0; m_rise = 0; m_fs = 0; m_flag = 0;
    #2;
    test_reset();
    test_phase_clock();
    test_line();
    test_gating();
    test_irq();
    test_frame();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
